// File: rtl/rat_pkg.sv
// Shared state encoding, direction codes and defaults for the rat-in-maze search controller.
package rat_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_INIT     = 4'd1;
    localparam state_t S_TRY      = 4'd2;
    localparam state_t S_EVAL     = 4'd3;
    localparam state_t S_ADVANCE  = 4'd4;
    localparam state_t S_EVAL_POS = 4'd5;
    localparam state_t S_BACK     = 4'd6;
    localparam state_t S_RETREAT  = 4'd7;
    localparam state_t S_REVERSE  = 4'd8;
    localparam state_t S_FOUND    = 4'd9;
    localparam state_t S_SHOW     = 4'd10;
    localparam state_t S_FAIL     = 4'd11;

    // Inverse direction is always code ^ 2, which the datapath relies on when backtracking.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int RAT_STEP_W_DEFAULT = 16;

    function automatic logic state_is_busy(input state_t s);
        return (s inside {S_INIT, S_TRY, S_EVAL, S_ADVANCE, S_EVAL_POS,
                          S_BACK, S_RETREAT, S_REVERSE});
    endfunction

endpackage

// File: rtl/rat_show_pacer.sv
// Spaces replayed moves: fires once when stack2 has data, then stays quiet for GAP cycles.
module rat_show_pacer
    import rat_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic empty_i,
    output logic fire_o
);

    localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [CW-1:0] gap_q, gap_d;

    assign fire_o = en_i && !empty_i && (gap_q == '0);

    always_comb begin
        gap_d = gap_q;
        if (!en_i) begin
            gap_d = '0;
        end else if (fire_o) begin
            gap_d = CW'(GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/rat_controller.sv
// Depth-first maze search sequencer with path reversal and paced replay.
// Optional RAT_STEP_COUNT_EN adds a saturating steps output counting advances and retreats.
//
// state    | meaning
// IDLE     | waiting for start
// INIT     | clear direction counter, search begins
// TRY      | load dir from counter, read candidate cell
// EVAL     | judge candidate: advance, next dir, or backtrack
// ADVANCE  | mark cell, push dir, move, clear counter
// EVAL_POS | goal check after a move
// BACK     | load inverse of stack1 top (or fail if empty)
// RETREAT  | step back, mark, pop, counter <- top+1
// REVERSE  | move stack1 into stack2
// FOUND    | path ready, waiting for run
// SHOW     | replay one move per pacer slot
// FAIL     | no path or overflow, waiting for start
module rat_controller
    import rat_pkg::*;
#(
    parameter int STEP_W   = RAT_STEP_W_DEFAULT,
    parameter int SHOW_GAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic invalid,
    input  logic finish,
    input  logic cout,
    input  logic top_last,
    input  logic empty1,
    input  logic full1,
    input  logic empty2,
    input  logic full2,
    output logic ldX,
    output logic ldY,
    output logic ldR,
    output logic ldC,
    output logic cen,
    output logic Izc,
    output logic Sel5,
    output logic push1,
    output logic pop1,
    output logic push2,
    output logic pop2,
    output logic mem_rd,
    output logic mem_mark,
    output logic busy,
    output logic found,
    output logic fail,
    output logic overflow,
`ifdef RAT_STEP_COUNT_EN
    output logic [STEP_W-1:0] steps,
`endif
    output logic move_valid
);

    if (STEP_W < 1 || SHOW_GAP < 0) begin : g_param_check
        $error("rat_controller: STEP_W must be >= 1 and SHOW_GAP >= 0");
    end

    state_t state_q, state_d;
    logic   overflow_q, overflow_d;
    logic   ovf_set;
    logic   show_fire;

    rat_show_pacer #(
        .GAP (SHOW_GAP)
    ) u_pacer (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q == S_SHOW),
        .empty_i (empty2),
        .fire_o  (show_fire)
    );

    always_comb begin
        state_d = state_q;
        ovf_set = 1'b0;
        case (state_q)
            S_IDLE:     if (start) state_d = S_INIT;
            S_INIT:     state_d = S_TRY;
            S_TRY:      state_d = S_EVAL;
            S_EVAL: begin
                if (finish) begin
                    state_d = S_REVERSE;
                end else if (!invalid && full1) begin
                    state_d = S_FAIL;
                    ovf_set = 1'b1;
                end else if (!invalid) begin
                    state_d = S_ADVANCE;
                end else if (!cout) begin
                    state_d = S_TRY;
                end else begin
                    state_d = S_BACK;
                end
            end
            S_ADVANCE:  state_d = S_EVAL_POS;
            S_EVAL_POS: state_d = finish ? S_REVERSE : S_TRY;
            S_BACK:     state_d = empty1 ? S_FAIL : S_RETREAT;
            // A popped top of 3 means the counter would wrap: this level is exhausted too.
            S_RETREAT:  state_d = top_last ? S_BACK : S_TRY;
            S_REVERSE: begin
                if (empty1) begin
                    state_d = S_FOUND;
                end else if (full2) begin
                    state_d = S_FAIL;
                    ovf_set = 1'b1;
                end
            end
            S_FOUND:    if (run) state_d = S_SHOW;
            S_SHOW:     if (empty2) state_d = S_IDLE;
            S_FAIL:     if (start) state_d = S_INIT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (state_d != S_FAIL) begin
            overflow_d = 1'b0;
        end else if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        ldX      = 1'b0;
        ldY      = 1'b0;
        ldR      = 1'b0;
        ldC      = 1'b0;
        cen      = 1'b0;
        Izc      = 1'b0;
        Sel5     = 1'b0;
        push1    = 1'b0;
        pop1     = 1'b0;
        push2    = 1'b0;
        pop2     = 1'b0;
        mem_rd   = 1'b0;
        mem_mark = 1'b0;
        case (state_q)
            S_INIT: begin
                ldC = 1'b1;
                Izc = 1'b1;
            end
            S_TRY: begin
                ldR    = 1'b1;
                mem_rd = 1'b1;
            end
            S_EVAL:    cen = invalid && !cout && !finish;
            S_ADVANCE: begin
                mem_mark = 1'b1;
                push1    = 1'b1;
                ldX      = 1'b1;
                ldY      = 1'b1;
                ldC      = 1'b1;
                Izc      = 1'b1;
            end
            S_BACK: begin
                ldR  = !empty1;
                Sel5 = !empty1;
            end
            S_RETREAT: begin
                ldX      = 1'b1;
                ldY      = 1'b1;
                mem_mark = 1'b1;
                ldC      = 1'b1;
                pop1     = 1'b1;
            end
            S_REVERSE: begin
                pop1  = !empty1 && !full2;
                push2 = !empty1 && !full2;
            end
            S_SHOW:    pop2 = show_fire;
            default: ;
        endcase
    end

    assign move_valid = (state_q == S_SHOW) && show_fire;
    assign busy       = state_is_busy(state_q);
    assign found      = (state_q == S_FOUND) || (state_q == S_SHOW);
    assign fail       = (state_q == S_FAIL);
    assign overflow   = overflow_q;

`ifdef RAT_STEP_COUNT_EN
    logic [STEP_W-1:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (state_q == S_INIT) begin
            steps_d = '0;
        end else if ((state_q == S_ADVANCE || state_q == S_RETREAT) && (steps_q != '1)) begin
            steps_d = steps_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`endif

endmodule

// File: tb/tb_rat_controller.sv
// Bench for rat_controller: a behavioural maze datapath around the DUT and a plain DFS reference.
`timescale 1ns/1ps
module tb_rat_controller;
    import rat_pkg::*;

    localparam int CAP = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic run = 1'b0;
    logic invalid, finish, cout, top_last, empty1, full1, empty2, full2;
    logic ldX, ldY, ldR, ldC, cen, Izc, Sel5, push1, pop1, push2, pop2;
    logic mem_rd, mem_mark, busy, found, fail, overflow, move_valid;
    logic [17:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rat_controller #(.STEP_W(16), .SHOW_GAP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .run(run),
        .invalid(invalid), .finish(finish), .cout(cout), .top_last(top_last),
        .empty1(empty1), .full1(full1), .empty2(empty2), .full2(full2),
        .ldX(ldX), .ldY(ldY), .ldR(ldR), .ldC(ldC), .cen(cen), .Izc(Izc), .Sel5(Sel5),
        .push1(push1), .pop1(pop1), .push2(push2), .pop2(pop2),
        .mem_rd(mem_rd), .mem_mark(mem_mark),
        .busy(busy), .found(found), .fail(fail), .overflow(overflow),
`ifdef RAT_STEP_COUNT_EN
        .steps(steps),
`endif
        .move_valid(move_valid)
    );

`ifdef RAT_STEP_COUNT_EN
    logic [15:0] steps;
    logic [1:0]  steps2;
    logic [17:0] d2;
    // Second instance sees identical inputs; only its narrow steps output is of interest.
    rat_controller #(.STEP_W(2), .SHOW_GAP(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .run(run),
        .invalid(invalid), .finish(finish), .cout(cout), .top_last(top_last),
        .empty1(empty1), .full1(full1), .empty2(empty2), .full2(full2),
        .ldX(d2[0]), .ldY(d2[1]), .ldR(d2[2]), .ldC(d2[3]), .cen(d2[4]), .Izc(d2[5]),
        .Sel5(d2[6]), .push1(d2[7]), .pop1(d2[8]), .push2(d2[9]), .pop2(d2[10]),
        .mem_rd(d2[11]), .mem_mark(d2[12]), .busy(d2[13]), .found(d2[14]),
        .fail(d2[15]), .overflow(d2[16]), .steps(steps2), .move_valid(d2[17])
    );
`endif

    assign outs = {ldX, ldY, ldR, ldC, cen, Izc, Sel5, push1, pop1, push2, pop2,
                   mem_rd, mem_mark, busy, found, fail, overflow, move_valid};

    // ---------------- behavioural datapath ----------------
    logic [3:0] x, y;
    logic [1:0] c, r;
    logic [1:0] s1 [CAP];
    logic [1:0] s2 [CAP];
    int sp1, sp2;
    bit [255:0] walls = '0;
    bit [255:0] marked;
    bit force_full1 = 1'b0;
    logic [1:0] top1, move;
    int cx, cy;

    function automatic int dxf(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int dyf(input int d);
        return (d == 0) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    always_comb begin
        top1 = (sp1 > 0) ? s1[sp1-1] : 2'd0;
        move = (sp2 > 0) ? s2[sp2-1] : 2'd0;
        cx = int'(x) + dxf(int'(r));
        cy = int'(y) + dyf(int'(r));
        if (cx < 0 || cx > 15 || cy < 0 || cy > 15) invalid = 1'b1;
        else invalid = walls[cx*16+cy] | marked[cx*16+cy];
        finish   = (x == 4'd15) && (y == 4'd15);
        cout     = (c == 2'd3);
        top_last = (sp1 > 0) && (top1 == 2'd3);
        empty1   = (sp1 == 0);
        full1    = force_full1 || (sp1 == CAP);
        empty2   = (sp2 == 0);
        full2    = (sp2 == CAP);
    end

    always @(posedge clk) begin
        if (rst) begin
            x <= 0; y <= 0; c <= 0; r <= 0; sp1 <= 0; sp2 <= 0; marked <= '0;
        end else begin
            if (ldC) c <= Izc ? 2'd0 : top1 + 2'd1;
            else if (cen) c <= c + 2'd1;
            if (ldR) r <= Sel5 ? (top1 ^ 2'd2) : c;
            if (ldX || ldY) begin x <= 4'(cx); y <= 4'(cy); end
            if (mem_mark) marked[{x, y}] <= 1'b1;
            if (push1 && !pop1) begin s1[sp1] <= r; sp1 <= sp1 + 1; end
            else if (pop1 && !push1) sp1 <= sp1 - 1;
            if (push2) begin s2[sp2] <= top1; sp2 <= sp2 + 1; end
            else if (pop2) sp2 <= sp2 - 1;
        end
    end

    // ---------------- event monitor ----------------
    int n_push1 = 0, n_ret = 0, n_ldxy = 0, n_ret_bad = 0, n_adj = 0;
    logic mv_prev = 1'b0;
    logic ret_pend = 1'b0;
    logic [1:0] ret_exp = 2'd0;

    always @(posedge clk) begin
        if (push1) n_push1 <= n_push1 + 1;
        if (ldX || ldY) n_ldxy <= n_ldxy + 1;
        if (move_valid && mv_prev) n_adj <= n_adj + 1;
        mv_prev <= move_valid;
        if (ret_pend && c !== ret_exp) n_ret_bad <= n_ret_bad + 1;
        ret_pend <= 1'b0;
        if (pop1 && !push2 && !rst) begin
            n_ret    <= n_ret + 1;
            ret_exp  <= top1 + 2'd1;
            ret_pend <= !top_last;
            if (!(ldC && !Izc && mem_mark)) n_ret_bad <= n_ret_bad + 1;
        end
    end

    // ---------------- reference DFS ----------------
    bit ref_ok;
    int ref_adv, ref_ret;
    logic [1:0] ref_path [$];
    logic [1:0] got [$];

    task automatic ref_search();
        bit vis [256];
        int px, py, nd, d, nx, ny;
        bit moved;
        ref_path.delete(); ref_adv = 0; ref_ret = 0; ref_ok = 0;
        for (int i = 0; i < 256; i++) vis[i] = walls[i];
        px = 0; py = 0; nd = 0; vis[0] = 1'b1;
        while (1) begin
            if (px == 15 && py == 15) begin ref_ok = 1; break; end
            moved = 0;
            for (int k = nd; k < 4 && !moved; k++) begin
                nx = px + dxf(k); ny = py + dyf(k);
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[nx*16+ny]) begin
                    ref_path.push_back(2'(k));
                    vis[nx*16+ny] = 1'b1;
                    px = nx; py = ny; ref_adv++; moved = 1;
                end
            end
            if (moved) nd = 0;
            else if (ref_path.size() == 0) break;
            else begin
                d = int'(ref_path.pop_back());
                px -= dxf(d); py -= dyf(d); ref_ret++; nd = d + 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; start = 1'b0; run = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        int cyc = 0;
        while (!(found || fail) && cyc < 20000) begin @(negedge clk); cyc++; end
        timed_out = !(found || fail);
    endtask

    task automatic do_replay(output bit timed_out);
        int cyc = 0;
        got.delete();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        while (cyc < 2000) begin
            if (move_valid) got.push_back(move);
            if (!found) break;
            @(negedge clk); cyc++;
        end
        timed_out = found;
    endtask

    function automatic int path_diff();
        if (got.size() != ref_path.size()) return -2;
        for (int i = 0; i < got.size(); i++) if (got[i] !== ref_path[i]) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (outs !== 18'd0) begin errors++; $display("FAIL reset_outputs got=%b want=0", outs); end
    endtask

    task automatic test_empty_maze();
        bit to; int p0, pd;
        apply_reset(); walls = '0; ref_search(); p0 = n_push1;
        @(negedge clk); start = 1'b1; run = 1'b1;
        @(negedge clk); start = 1'b0; run = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_wins got busy=%b want=1", busy); end
        wait_done(to);
        checks++;
        if (to || found !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL empty_found got found=%b fail=%b timeout=%0d want found=1", found, fail, to);
        end
        checks++;
        if (n_push1 - p0 != 30) begin errors++; $display("FAIL empty_pushes got=%0d want=30", n_push1 - p0); end
        checks++;
        if (ref_adv != 30) begin errors++; $display("FAIL empty_ref_pushes got=%0d want=30", ref_adv); end
        do_replay(to);
        checks++;
        if (got.size() != 30) begin errors++; $display("FAIL empty_replay_len got=%0d want=30", got.size()); end
        checks++;
        if (got.size() == 0 || got[0] !== DIR_UP) begin errors++; $display("FAIL empty_first_move got=%0d want=%0d", (got.size() > 0) ? got[0] : 2'd0, DIR_UP); end
        pd = path_diff();
        checks++;
        if (pd != -1) begin errors++; $display("FAIL empty_path got diff_at=%0d want=-1", pd); end
        checks++;
        if (to || found !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_back_idle got found=%b busy=%b", found, busy); end
        checks++;
        if (n_adj != 0) begin errors++; $display("FAIL replay_gap got adjacent=%0d want=0", n_adj); end
    endtask

    task automatic test_boxed();
        bit to; int p0;
        apply_reset(); walls = '0; walls[1*16+0] = 1'b1; walls[0*16+1] = 1'b1;
        ref_search(); p0 = n_push1;
        pulse_start(); wait_done(to);
        checks++;
        if (to || fail !== 1'b1 || found !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL boxed_status got fail=%b found=%b ovf=%b want 1/0/0", fail, found, overflow);
        end
        checks++;
        if (fail !== !ref_ok) begin errors++; $display("FAIL boxed_ref got fail=%b want=%b", fail, !ref_ok); end
        checks++;
        if (n_push1 != p0) begin errors++; $display("FAIL boxed_pushes got=%0d want=0", n_push1 - p0); end
    endtask

    task automatic test_dead_end();
        bit to; int p0, r0, b0, pd;
        apply_reset(); walls = '0;
        walls[0*16+4] = 1'b1; walls[1*16+1] = 1'b1; walls[1*16+2] = 1'b1; walls[1*16+3] = 1'b1;
        ref_search(); p0 = n_push1; r0 = n_ret; b0 = n_ret_bad;
        pulse_start(); wait_done(to);
        checks++;
        if (to || found !== 1'b1) begin errors++; $display("FAIL dead_found got found=%b want=1", found); end
        checks++;
        if (n_ret - r0 != 3 || ref_ret != 3) begin errors++; $display("FAIL dead_retreats got=%0d ref=%0d want=3", n_ret - r0, ref_ret); end
        checks++;
        if (n_push1 - p0 != ref_adv) begin errors++; $display("FAIL dead_pushes got=%0d want=%0d", n_push1 - p0, ref_adv); end
        checks++;
        if (n_ret_bad != b0) begin errors++; $display("FAIL dead_counter_load got bad=%0d want=0", n_ret_bad - b0); end
`ifdef RAT_STEP_COUNT_EN
        checks++;
        if (int'(steps) != ref_adv + ref_ret) begin errors++; $display("FAIL dead_steps got=%0d want=%0d", steps, ref_adv + ref_ret); end
        checks++;
        if (steps2 !== 2'd3) begin errors++; $display("FAIL dead_steps_sat got=%0d want=3", steps2); end
`endif
        do_replay(to);
        pd = path_diff();
        checks++;
        if (to || pd != -1) begin errors++; $display("FAIL dead_path got diff_at=%0d timeout=%0d want=-1", pd, to); end
    endtask

    task automatic test_full1();
        bit to; int l0;
        apply_reset(); walls = '0; force_full1 = 1'b1; l0 = n_ldxy;
        pulse_start(); wait_done(to);
        checks++;
        if (to || fail !== 1'b1 || overflow !== 1'b1 || found !== 1'b0) begin
            errors++; $display("FAIL full1_status got fail=%b ovf=%b found=%b want 1/1/0", fail, overflow, found);
        end
        checks++;
        if (n_ldxy != l0) begin errors++; $display("FAIL full1_no_move got=%0d want=0", n_ldxy - l0); end
        force_full1 = 1'b0;
        pulse_start();
        checks++;
        if (fail !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL fail_restart got fail=%b ovf=%b busy=%b want 0/0/1", fail, overflow, busy);
        end
    endtask

    task automatic test_rst_mid_reverse();
        bit to; int cyc = 0;
        apply_reset(); walls = '0; ref_search();
        pulse_start();
        while (!push2 && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++;
        if (push2 !== 1'b1) begin errors++; $display("FAIL reverse_reached got push2=%b want=1", push2); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (outs !== 18'd0) begin errors++; $display("FAIL mid_reverse_rst got=%b want=0", outs); end
        pulse_start(); wait_done(to);
        do_replay(to);
        checks++;
        if (to || got.size() != 30 || path_diff() != -1) begin
            errors++; $display("FAIL rerun_after_rst got len=%0d want=30", got.size());
        end
    endtask

    task automatic test_random();
        bit to; int p0, r0, pd;
        for (int m = 0; m < 5; m++) begin
            apply_reset();
            for (int i = 0; i < 256; i++) walls[i] = ($urandom_range(0, 99) < 25);
            walls[0] = 1'b0; walls[255] = 1'b0;
            ref_search(); p0 = n_push1; r0 = n_ret;
            pulse_start(); wait_done(to);
            checks++;
            if (to || found !== ref_ok || fail !== !ref_ok) begin
                errors++; $display("FAIL rand%0d_outcome got found=%b fail=%b want found=%b", m, found, fail, ref_ok);
            end
            checks++;
            if (n_push1 - p0 != ref_adv || n_ret - r0 != ref_ret) begin
                errors++; $display("FAIL rand%0d_counts got adv=%0d ret=%0d want adv=%0d ret=%0d", m, n_push1 - p0, n_ret - r0, ref_adv, ref_ret);
            end
`ifdef RAT_STEP_COUNT_EN
            checks++;
            if (int'(steps) != ref_adv + ref_ret) begin errors++; $display("FAIL rand%0d_steps got=%0d want=%0d", m, steps, ref_adv + ref_ret); end
`endif
            if (ref_ok) begin
                do_replay(to);
                pd = path_diff();
                checks++;
                if (to || pd != -1) begin errors++; $display("FAIL rand%0d_path got diff_at=%0d want=-1", m, pd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_maze();
        test_boxed();
        test_dead_end();
        test_full1();
        test_rst_mid_reverse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rat_controller.md
Name: rat_controller

Overview:
- Control FSM that sequences the rat-in-maze datapath: X/Y position registers, direction register, 2-bit direction counter, and two 2-bit direction stacks.
- Runs a depth-first search with backtracking from (0,0) to (15,15).
- On success, reverses stack1 into stack2, then replays the path one move at a time on request.
- Issues every datapath load/enable/select/push/pop strobe and the maze-memory read/mark strobes.

Parameters:
STEP_W, 16, width of the optional step counter.
SHOW_GAP, 1, idle cycles between replayed moves (0 = one move per cycle).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin search (sampled in IDLE only)
run  in  1  begin path replay (sampled in FOUND only)
invalid  in  1  candidate move hits a border or wall (includes memory Dout)
finish  in  1  current position is (15,15)
cout  in  1  direction counter at 3 (all four directions tried after this one)
top_last  in  1  stack1 top == 3
empty1, full1, empty2, full2  in  1 each  stack status
ldX, ldY, ldR, ldC, cen, Izc, Sel5  out  1 each  datapath controls
push1, pop1, push2, pop2  out  1 each  stack controls
mem_rd  out  1  maze read of candidate cell
mem_mark  out  1  write current cell as blocked (visited)
busy, found, fail, overflow  out  1 each  status
move_valid  out  1  Move (from datapath) is a valid replayed step

Behaviour:
- Reset: state IDLE; all outputs 0.
- Single clock `clk`; synchronous active-high `rst`; `rst` mid-operation aborts to IDLE within one cycle. The datapath shares `rst`, so stacks and registers clear together.
- All strobes are Moore outputs, one cycle wide.
- IDLE: start -> INIT.
- INIT: ldC=1, Izc=1 (counter <- 0); busy=1 from here until FOUND/FAIL -> TRY.
- TRY: ldR=1, Sel5=0 (dir <- count); mem_rd=1 -> EVAL. Memory has 1-cycle latency, so invalid is valid in EVAL.
- EVAL:
  - finish=1 -> REVERSE (reached without moving; start cell is goal).
  - invalid=0 and full1=1 -> FAIL with overflow=1.
  - invalid=0 -> ADVANCE.
  - invalid=1 and cout=0 -> cen=1 -> TRY.
  - invalid=1 and cout=1 -> BACK.
- ADVANCE: mem_mark=1, push1=1 (push dir), ldX/ldY=1 (the datapath muxes pick the axis), ldC=1, Izc=1 -> EVAL_POS.
- EVAL_POS: finish -> REVERSE, else TRY.
- BACK:
  - empty1=1 -> FAIL (no path).
  - else ldR=1, Sel5=1 (dir <- inverse of top) -> RETREAT.
- RETREAT: ldX/ldY=1 (step back), mem_mark=1, ldC=1, Izc=0 (counter <- top+1), pop1=1.
  - top_last=1 -> BACK (2-bit counter wrapped; this level is exhausted).
  - else -> TRY.
- REVERSE:
  - each cycle with empty1=0: pop1=1, push2=1 (top moves stack1 -> stack2).
  - empty1=1 -> FOUND.
  - full2 during a push -> FAIL, overflow=1.
- FOUND: found=1, busy=0; run -> SHOW.
- SHOW: if empty2=0: move_valid=1, pop2=1, then SHOW_GAP idle cycles; empty2=1 -> IDLE (found cleared).
- FAIL: fail=1 held; start -> INIT (fail/overflow cleared).
- Simultaneous start and run in IDLE: start wins; run is ignored outside FOUND.

Optional Feature:
- Macro RAT_STEP_COUNT_EN.
- Defined: adds output steps[STEP_W-1:0], cleared in INIT, +1 per ADVANCE and per RETREAT, saturating at all-ones, held through FOUND/FAIL.
- Undefined: no port, no counter logic.

Decomposition:
- Package rat_pkg: state enum (IDLE, INIT, TRY, EVAL, ADVANCE, EVAL_POS, BACK, RETREAT, REVERSE, FOUND, SHOW, FAIL), direction constants (UP=0, RIGHT=1, DOWN=2, LEFT=3), default STEP_W.
- One sub-module is natural: rat_show_pacer (SHOW_GAP down-counter that gates pop2/move_valid).
- The FSM stays in rat_controller.

Test Plan:
- Empty maze (no walls), start -> found after a path of 30 pushes. Replay via run gives exactly 30 move_valid pulses, first Move matches the first pushed direction, then returns to IDLE.
- Wall at (1,0) and (0,1) -> stack1 stays empty; BACK sees empty1 -> fail=1, found=0, no push1 ever asserted.
- Dead-end corridor of length 3 -> three RETREAT visits, pop1 count == push1 count on that branch, search continues, and each retreat's counter load equals top+1.
- Stack full (full1 tied 1) on first valid move -> fail=1, overflow=1, no ldX/ldY pulse.
- rst asserted mid-REVERSE -> next cycle IDLE with all outputs 0; a new start then runs the full search again.
- With RAT_STEP_COUNT_EN defined, dead-end maze -> steps == ADVANCE count + RETREAT count; STEP_W=2 saturates at 3.
